// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data access path.
// Holds the access-size encodings, the FSM state encoding, and helpers that
// derive byte enables, store-data replication and alignment from size/address.
package mips_mem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  // 2'b11 is reserved and handled as a word everywhere.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~a[0];
      default: ok = (a == 2'b00);
    endcase
    return ok;
  endfunction

  // Little-endian lane enables.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Sub-word stores are replicated so the enabled lanes always see the data.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wd[7:0]}};
      SZ_HALF: d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Simple request/acknowledge memory bus.
//   bus_req   : access in progress (master)
//   bus_we    : 1 = write, 0 = read (master)
//   bus_addr  : word-aligned byte address (master)
//   bus_wdata : write data, lanes replicated (master)
//   bus_be    : byte enables (master)
//   bus_ack   : access complete this cycle (slave)
//   bus_rdata : read data, valid with bus_ack (slave)
interface mem_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_align.sv
// Combinational load formatter: selects the addressed byte/half lane from a
// bus word and sign- or zero-extends it.
//   rdata_i    : raw bus read word
//   addr_i     : low two address bits of the load
//   size_i     : access size (word/half/byte; reserved = word)
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o     : formatted 32-bit result
module load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    case (addr_i)
      2'd0: byte_v = rdata_i[7:0];
      2'd1: byte_v = rdata_i[15:8];
      2'd2: byte_v = rdata_i[23:16];
      2'd3: byte_v = rdata_i[31:24];
      default: byte_v = rdata_i[7:0];
    endcase
    half_v = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
      SZ_HALF: data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit. Accepts one aligned access from the EX/MEM
// register, runs a req/ack bus cycle, and formats load data for MEM/WB.
//   clk, reset                : clock, synchronous active-high reset
//   Ex_Valid/MemRd/MemWr      : live instruction, load/store request
//   Ex_Size, Ex_Unsigned      : access size, zero-extend sub-word loads
//   Ex_ALUOut, Ex_WrData      : byte address, store data
//   Mem_outB                  : formatted load data (held between loads)
//   Mem_Stall                 : freezes upstream pipeline registers
//   Mem_AddrErr               : one-cycle misaligned-access pulse
//   bus                       : master side of mem_access_if
module mem_access
  import mips_mem_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         Ex_Valid,
  input  logic         Ex_MemRd,
  input  logic         Ex_MemWr,
  input  logic [1:0]   Ex_Size,
  input  logic         Ex_Unsigned,
  input  logic [31:0]  Ex_ALUOut,
  input  logic [31:0]  Ex_WrData,
  output logic [31:0]  Mem_outB,
  output logic         Mem_Stall,
  output logic         Mem_AddrErr,
  mem_access_if.master bus
);

  mem_state_e  state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] outb_q;
  logic        err_q;
  logic [1:0]  ld_size_q;
  logic        ld_uns_q;
  logic [1:0]  ld_lane_q;

  logic        req_valid;
  logic        aligned;
  logic        accept;
  logic        misalign;
  logic [31:0] load_data;

  assign req_valid = Ex_Valid & (Ex_MemRd | Ex_MemWr);
  assign aligned   = is_aligned(Ex_Size, Ex_ALUOut[1:0]);
  // Only IDLE may take a new access; in DONE the EX/MEM register still shows
  // the instruction that just completed.
  assign accept    = (state_q == IDLE) & req_valid & aligned;
  assign misalign  = (state_q == IDLE) & req_valid & ~aligned;
  assign Mem_Stall = accept | (state_q == WAIT);

  load_align u_load_align (
    .rdata_i    (bus.bus_rdata),
    .addr_i     (ld_lane_q),
    .size_i     (ld_size_q),
    .unsigned_i (ld_uns_q),
    .data_o     (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      outb_q    <= '0;
      err_q     <= 1'b0;
      ld_size_q <= SZ_WORD;
      ld_uns_q  <= 1'b0;
      ld_lane_q <= '0;
    end else begin
      err_q <= misalign;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= WAIT;
            req_q     <= 1'b1;
            we_q      <= Ex_MemWr;
            addr_q    <= {Ex_ALUOut[31:2], 2'b00};
            be_q      <= lane_be(Ex_Size, Ex_ALUOut[1:0]);
            wdata_q   <= store_data(Ex_Size, Ex_WrData);
            ld_size_q <= Ex_Size;
            ld_uns_q  <= Ex_Unsigned;
            ld_lane_q <= Ex_ALUOut[1:0];
          end
        end
        WAIT: begin
          if (bus.bus_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            if (!we_q) outb_q <= load_data;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;
  assign Mem_outB      = outb_q;
  assign Mem_AddrErr   = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access. Inputs change on the falling
// edge; outputs are sampled 1 ns later. Expected load results are queued when
// an access is issued and popped when the DONE cycle is reached.
module tb_mem_access;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Ex_Valid, Ex_MemRd, Ex_MemWr, Ex_Unsigned;
  logic [1:0]  Ex_Size;
  logic [31:0] Ex_ALUOut, Ex_WrData;
  logic [31:0] Mem_outB;
  logic        Mem_Stall, Mem_AddrErr;

  mem_access_if bus_if();

  mem_access dut (
    .clk         (clk),
    .reset       (reset),
    .Ex_Valid    (Ex_Valid),
    .Ex_MemRd    (Ex_MemRd),
    .Ex_MemWr    (Ex_MemWr),
    .Ex_Size     (Ex_Size),
    .Ex_Unsigned (Ex_Unsigned),
    .Ex_ALUOut   (Ex_ALUOut),
    .Ex_WrData   (Ex_WrData),
    .Mem_outB    (Mem_outB),
    .Mem_Stall   (Mem_Stall),
    .Mem_AddrErr (Mem_AddrErr),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          bus_cycles = 0;
  logic        prev_req = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] last_outb;

  // Count rising edges of bus_req, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus_if.bus_req === 1'b1 && prev_req === 1'b0) bus_cycles++;
    prev_req = bus_if.bus_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = rd >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? rd[31:16] : rd[15:0];
    if (sz == 2'b10) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'b01) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return rd;
  endfunction

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    Ex_Valid = v; Ex_MemRd = rd; Ex_MemWr = wr; Ex_Size = sz;
    Ex_Unsigned = uns; Ex_ALUOut = a; Ex_WrData = wd;
  endtask

  // One complete aligned access: accept cycle, `waits` WAIT cycles (ack on the
  // last), then DONE. The instruction stays on the Ex inputs through DONE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input int waits);
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] e;
    case (sz)
      2'b10: begin ebe = 4'b0001 << a[1:0]; ewd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
      2'b01: begin ebe = a[1] ? 4'b1100 : 4'b0011; ewd = {wd[15:0], wd[15:0]}; end
      default: begin ebe = 4'b1111; ewd = wd; end
    endcase
    if (!wr) exp_q.push_back(model_load(sz, uns, a[1:0], rdata));

    @(negedge clk);
    drive(1'b1, rd, wr, sz, uns, a, wd);
    bus_if.bus_ack = 1'b0;
    #1;
    chk({tag, " accept stall"}, 32'(Mem_Stall), 1);
    chk({tag, " accept req"}, 32'(bus_if.bus_req), 0);

    for (int k = 0; k < waits; k++) begin
      @(negedge clk);
      bus_if.bus_ack   = (k == waits - 1);
      bus_if.bus_rdata = (k == waits - 1) ? rdata : $urandom;
      #1;
      chk({tag, " wait req"}, 32'(bus_if.bus_req), 1);
      chk({tag, " wait stall"}, 32'(Mem_Stall), 1);
      chk({tag, " addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
      chk({tag, " be"}, 32'(bus_if.bus_be), 32'(ebe));
      chk({tag, " we"}, 32'(bus_if.bus_we), 32'(wr));
      if (wr) chk({tag, " wdata"}, bus_if.bus_wdata, ewd);
    end

    @(negedge clk);
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = $urandom;
    #1;
    chk({tag, " done stall"}, 32'(Mem_Stall), 0);
    chk({tag, " done req"}, 32'(bus_if.bus_req), 0);
    if (!wr) begin
      if (exp_q.size() == 0) begin
        chk({tag, " scoreboard empty"}, 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        chk({tag, " outB"}, Mem_outB, e);
        last_outb = e;
      end
    end else begin
      chk({tag, " outB held"}, Mem_outB, last_outb);
    end
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    bus_if.bus_ack = 1'b0;
    #1;
    chk({tag, " idle req"}, 32'(bus_if.bus_req), 0);
    chk({tag, " idle stall"}, 32'(Mem_Stall), 0);
  endtask

  task automatic misaligned(input string tag, input logic rd, input logic wr,
                            input logic [1:0] sz, input logic [31:0] a);
    @(negedge clk);
    drive(1'b1, rd, wr, sz, 1'b0, a, 32'hA5A5_5A5A);
    #1;
    chk({tag, " stall"}, 32'(Mem_Stall), 0);
    chk({tag, " req0"}, 32'(bus_if.bus_req), 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    #1;
    chk({tag, " err pulse"}, 32'(Mem_AddrErr), 1);
    chk({tag, " req1"}, 32'(bus_if.bus_req), 0);
    chk({tag, " outB held"}, Mem_outB, last_outb);
    @(negedge clk);
    #1;
    chk({tag, " err end"}, 32'(Mem_AddrErr), 0);
    chk({tag, " req2"}, 32'(bus_if.bus_req), 0);
  endtask

  initial begin
    int c0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    last_outb = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst req", 32'(bus_if.bus_req), 0);
    chk("rst we", 32'(bus_if.bus_we), 0);
    chk("rst be", 32'(bus_if.bus_be), 0);
    chk("rst addr", bus_if.bus_addr, 0);
    chk("rst wdata", bus_if.bus_wdata, 0);
    chk("rst outB", Mem_outB, 0);
    chk("rst err", 32'(Mem_AddrErr), 0);
    chk("rst stall", 32'(Mem_Stall), 0);
    chk("rst state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;

    idle("start");

    // Stray ack while idle must not start or complete anything.
    @(negedge clk);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    chk("stray ack req", 32'(bus_if.bus_req), 0);
    chk("stray ack outB", Mem_outB, 0);
    chk("stray ack state", 32'(dut.state_q), 32'(IDLE));

    access("lw100", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2);
    idle("after lw");
    access("lb103", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0011, 1);
    access("lbu103", 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_0011, 1);
    access("lh102", 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 3);
    access("lhu100", 1'b1, 1'b0, SZ_HALF, 1'b1, 32'h0000_0100, 32'h0, 32'h8001_7FFF, 1);
    access("lb101", 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0101, 32'h0, 32'h1234_7F56, 1);
    access("sh202", 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 1);
    // Both request lines high: the store must win.
    access("sb201", 1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h0000_0201, 32'h0000_0055, 32'h0, 2);
    access("lw_rsv", 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0208, 32'h0, 32'h8765_4321, 1);
    idle("after set");

    misaligned("lw101", 1'b1, 1'b0, SZ_WORD, 32'h0000_0101);
    misaligned("lh103", 1'b1, 1'b0, SZ_HALF, 32'h0000_0103);
    misaligned("sw302", 1'b0, 1'b1, SZ_WORD, 32'h0000_0302);

    // Reset in the middle of WAIT; the ack arriving afterwards is ignored.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0400, 32'h0);
    #1;
    chk("rstwait accept", 32'(Mem_Stall), 1);
    @(negedge clk);
    #1;
    chk("rstwait req", 32'(bus_if.bus_req), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h1234_5678;
    #1;
    chk("rstwait req0", 32'(bus_if.bus_req), 0);
    chk("rstwait stall", 32'(Mem_Stall), 0);
    chk("rstwait state", 32'(dut.state_q), 32'(IDLE));
    chk("rstwait outB", Mem_outB, 0);
    last_outb = '0;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    chk("late ack req", 32'(bus_if.bus_req), 0);
    chk("late ack outB", Mem_outB, 0);
    chk("late ack state", 32'(dut.state_q), 32'(IDLE));

    // Back-to-back store then load, ack on the first WAIT cycle.
    c0 = bus_cycles;
    access("b2b sw", 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 1);
    access("b2b lw", 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0304, 32'h0, 32'h1357_9BDF, 1);
    idle("b2b end");
    idle("b2b end2");
    chk("b2b bus cycles", 32'(bus_cycles - c0), 2);

    chk("scoreboard drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
